pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- hazard, branch and halt controller for a short in-order pipeline
// (IF -> IF_ID -> DEC -> DEC_ALU -> ALU -> ALU_MEM -> MEM -> MEM_WB -> WB).
//
// A three-entry scoreboard mirrors the destination registers held in DEC_ALU,
// ALU_MEM and MEM_WB. The controller stalls decode on a read-after-write hit
// against any valid entry and redirects the PC on a resolved branch. On a halt
// request it discards the decode instruction and waits until the scoreboard
// has emptied before it reports halted.
//
// Ports
//   clk            : clock, rising edge
//   resetIn        : synchronous active-high reset
//   decRead1/2     : decode source register addresses
//   decUse1/2      : decode source actually read
//   decWrite       : decode destination register
//   decWriteEnable : decode destination is written
//   branchTaken    : resolved jump from the ALU stage (same cycle)
//   branchTarget   : jump address
//   haltReq        : level request to drain and stop
//   pcEnable       : PC advances
//   pcSelect       : PC loads pcJump instead of the sequential address
//   pcJump         : jump address towards the PC
//   ifidEnable     : IF_ID captures a new instruction
//   ifidFlush      : IF_ID is invalidated
//   decAluBubble   : DEC_ALU captures a NOP instead of the decode outputs
//   halted         : controller has stopped
//   state          : current controller state
//   stallCnt       : saturating count of hazard stalls
//   flushCnt       : saturating count of branch flushes
// -----------------------------------------------------------------------------
module pipe_ctrl (
  input  logic       clk,
  input  logic       resetIn,
  input  logic [4:0] decRead1,
  input  logic [4:0] decRead2,
  input  logic       decUse1,
  input  logic       decUse2,
  input  logic [4:0] decWrite,
  input  logic       decWriteEnable,
  input  logic       branchTaken,
  input  logic [5:0] branchTarget,
  input  logic       haltReq,
  output logic       pcEnable,
  output logic       pcSelect,
  output logic [5:0] pcJump,
  output logic       ifidEnable,
  output logic       ifidFlush,
  output logic       decAluBubble,
  output logic       halted,
  output logic [2:0] state,
  output logic [7:0] stallCnt,
  output logic [7:0] flushCnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STALL  = 3'd2,
    S_FLUSH  = 3'd3,
    S_DRAIN  = 3'd4,
    S_HALTED = 3'd5
  } state_e;

  state_e     state_q, state_d;

  // Scoreboard: entry 0 = DEC_ALU, 1 = ALU_MEM, 2 = MEM_WB
  logic       sb0_v_q, sb1_v_q, sb2_v_q;
  logic [4:0] sb0_a_q, sb1_a_q, sb2_a_q;
  logic       sb0_v_d;

  logic [7:0] stall_cnt_q, stall_cnt_d;
  logic [7:0] flush_cnt_q, flush_cnt_d;

  logic       hazard_s;
  logic       sb_empty_s;
  logic       stall_inc_s;
  logic       flush_inc_s;

  // True when a used, non-x0 source matches any valid in-flight destination.
  function automatic logic src_hit(
    input logic       use_i,
    input logic [4:0] addr_i,
    input logic       v0_i,
    input logic [4:0] a0_i,
    input logic       v1_i,
    input logic [4:0] a1_i,
    input logic       v2_i,
    input logic [4:0] a2_i
  );
    return use_i && (addr_i != 5'd0) &&
           ((v0_i && (a0_i == addr_i)) ||
            (v1_i && (a1_i == addr_i)) ||
            (v2_i && (a2_i == addr_i)));
  endfunction

  // Increment that sticks at the top value instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] val_i);
    return (val_i == 8'hFF) ? 8'hFF : (val_i + 8'd1);
  endfunction

  assign hazard_s =
    src_hit(decUse1, decRead1, sb0_v_q, sb0_a_q, sb1_v_q, sb1_a_q, sb2_v_q, sb2_a_q) ||
    src_hit(decUse2, decRead2, sb0_v_q, sb0_a_q, sb1_v_q, sb1_a_q, sb2_v_q, sb2_a_q);

  assign sb_empty_s = !sb0_v_q && !sb1_v_q && !sb2_v_q;

  // Next-state and pipeline control; reset forces the IDLE output values.
  always_comb begin
    state_d      = state_q;
    pcEnable     = 1'b1;
    ifidEnable   = 1'b1;
    pcSelect     = 1'b0;
    pcJump       = 6'd0;
    ifidFlush    = 1'b0;
    decAluBubble = 1'b0;
    halted       = 1'b0;
    stall_inc_s  = 1'b0;
    flush_inc_s  = 1'b0;

    if (resetIn) begin
      pcEnable     = 1'b0;
      ifidEnable   = 1'b0;
      decAluBubble = 1'b1;
      state_d      = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          pcEnable     = 1'b0;
          ifidEnable   = 1'b0;
          decAluBubble = 1'b1;
          state_d      = S_RUN;
        end
        S_RUN, S_STALL, S_FLUSH: begin
          // In FLUSH the ALU stage holds a bubble, so its branch flag is stale.
          if (branchTaken && (state_q != S_FLUSH)) begin
            pcSelect     = 1'b1;
            pcJump       = branchTarget;
            ifidFlush    = 1'b1;
            decAluBubble = 1'b1;
            flush_inc_s  = 1'b1;
            state_d      = S_FLUSH;
          end else if (hazard_s) begin
            pcEnable     = 1'b0;
            ifidEnable   = 1'b0;
            decAluBubble = 1'b1;
            stall_inc_s  = 1'b1;
            state_d      = S_STALL;
          end else if (haltReq) begin
            // The decode instruction is dropped; fetch resumes after reset.
            pcEnable     = 1'b0;
            ifidEnable   = 1'b0;
            decAluBubble = 1'b1;
            state_d      = S_DRAIN;
          end else begin
            state_d      = S_RUN;
          end
        end
        S_DRAIN: begin
          pcEnable     = 1'b0;
          ifidEnable   = 1'b0;
          decAluBubble = 1'b1;
          if (sb_empty_s) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_HALTED: begin
          pcEnable     = 1'b0;
          ifidEnable   = 1'b0;
          decAluBubble = 1'b1;
          halted       = 1'b1;
          state_d      = S_HALTED;
        end
        default: begin
          // Unused encodings fall back to IDLE with the pipeline frozen.
          pcEnable     = 1'b0;
          ifidEnable   = 1'b0;
          decAluBubble = 1'b1;
          state_d      = S_IDLE;
        end
      endcase
    end
  end

  // Entry written into DEC_ALU: writes to x0 never create a dependency.
  always_comb begin
    sb0_v_d = !decAluBubble && decWriteEnable && (decWrite != 5'd0);
  end

  // Saturating counter next values.
  always_comb begin
    stall_cnt_d = stall_inc_s ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = flush_inc_s ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (resetIn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scoreboard shift register tracking destinations in flight.
  always_ff @(posedge clk) begin
    if (resetIn) begin
      sb0_v_q <= 1'b0;
      sb1_v_q <= 1'b0;
      sb2_v_q <= 1'b0;
      sb0_a_q <= 5'd0;
      sb1_a_q <= 5'd0;
      sb2_a_q <= 5'd0;
    end else begin
      sb2_v_q <= sb1_v_q;
      sb2_a_q <= sb1_a_q;
      sb1_v_q <= sb0_v_q;
      sb1_a_q <= sb0_a_q;
      sb0_v_q <= sb0_v_d;
      sb0_a_q <= decWrite;
    end
  end

  // Stall and flush event counters.
  always_ff @(posedge clk) begin
    if (resetIn) begin
      stall_cnt_q <= 8'd0;
      flush_cnt_q <= 8'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state    = state_q;
  assign stallCnt = stall_cnt_q;
  assign flushCnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl.
// Each cycle's inputs and expected outputs form one record; the record is
// queued when the inputs are driven and popped/compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       resetIn;
  logic [4:0] decRead1, decRead2, decWrite;
  logic       decUse1, decUse2, decWriteEnable;
  logic       branchTaken;
  logic [5:0] branchTarget;
  logic       haltReq;
  logic       pcEnable, pcSelect, ifidEnable, ifidFlush, decAluBubble, halted;
  logic [5:0] pcJump;
  logic [2:0] state;
  logic [7:0] stallCnt, flushCnt;

  int checks = 0;
  int errors = 0;

  // ctrl = {pcEnable, pcSelect, ifidEnable, ifidFlush, decAluBubble, halted}
  localparam logic [5:0] P_RUN  = 6'b101000;
  localparam logic [5:0] P_HOLD = 6'b000010;
  localparam logic [5:0] P_BR   = 6'b111110;
  localparam logic [5:0] P_HLT  = 6'b000011;

  typedef struct {
    string      tag;
    logic       rst;
    logic [4:0] r1;
    logic       u1;
    logic [4:0] r2;
    logic       u2;
    logic [4:0] w;
    logic       we;
    logic       bt;
    logic [5:0] tgt;
    logic       halt;
    logic [5:0] e_ctrl;
    logic [5:0] e_jump;
    logic [2:0] e_state;
    logic [7:0] e_stall;
    logic [7:0] e_flush;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[18];

  pipe_ctrl dut (
    .clk(clk), .resetIn(resetIn),
    .decRead1(decRead1), .decRead2(decRead2),
    .decUse1(decUse1), .decUse2(decUse2),
    .decWrite(decWrite), .decWriteEnable(decWriteEnable),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .haltReq(haltReq),
    .pcEnable(pcEnable), .pcSelect(pcSelect), .pcJump(pcJump),
    .ifidEnable(ifidEnable), .ifidFlush(ifidFlush),
    .decAluBubble(decAluBubble), .halted(halted),
    .state(state), .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(
    input string tag, input logic rst,
    input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
    input logic [4:0] w, input logic we, input logic bt, input logic [5:0] tgt,
    input logic halt, input logic [5:0] ctrl, input logic [5:0] jump,
    input logic [2:0] st, input logic [7:0] sc, input logic [7:0] fc);
    vec_t v;
    v.tag = tag; v.rst = rst; v.r1 = r1; v.u1 = u1; v.r2 = r2; v.u2 = u2;
    v.w = w; v.we = we; v.bt = bt; v.tgt = tgt; v.halt = halt;
    v.e_ctrl = ctrl; v.e_jump = jump; v.e_state = st;
    v.e_stall = sc; v.e_flush = fc;
    return v;
  endfunction

  task automatic cmp(input string tag, input string what,
                     input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", tag, what, act, exp);
    end
  endtask

  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: no expected record queued");
    end else begin
      e = exp_q.pop_front();
      cmp(e.tag, "ctrl", {2'b00, pcEnable, pcSelect, ifidEnable, ifidFlush, decAluBubble, halted},
          {2'b00, e.e_ctrl});
      cmp(e.tag, "pcJump", {2'b00, pcJump}, {2'b00, e.e_jump});
      cmp(e.tag, "state", {5'd0, state}, {5'd0, e.e_state});
      cmp(e.tag, "stallCnt", stallCnt, e.e_stall);
      cmp(e.tag, "flushCnt", flushCnt, e.e_flush);
    end
  endtask

  // Drive one cycle, queue its expectation, compare on the falling edge.
  task automatic step(input vec_t v);
    resetIn        = v.rst;
    decRead1       = v.r1;
    decUse1        = v.u1;
    decRead2       = v.r2;
    decUse2        = v.u2;
    decWrite       = v.w;
    decWriteEnable = v.we;
    branchTaken    = v.bt;
    branchTarget   = v.tgt;
    haltReq        = v.halt;
    exp_q.push_back(v);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int haz;
    vec_t v;

    //            tag            rst r1    u1 r2    u2 w     we bt tgt    hlt ctrl   jump   st    stall  flush
    tbl[0]  = mk("rst",          1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_HOLD, 6'h00, 3'd0, 8'd0, 8'd0);
    tbl[1]  = mk("idle",         0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_HOLD, 6'h00, 3'd0, 8'd0, 8'd0);
    tbl[2]  = mk("wr_x0",        0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 6'h00, 0, P_RUN,  6'h00, 3'd1, 8'd0, 8'd0);
    tbl[3]  = mk("rd_x0",        0, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 6'h00, 0, P_RUN,  6'h00, 3'd1, 8'd0, 8'd0);
    tbl[4]  = mk("wr_x5",        0, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 6'h00, 0, P_RUN,  6'h00, 3'd1, 8'd0, 8'd0);
    tbl[5]  = mk("raw_x5_1",     0, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_HOLD, 6'h00, 3'd1, 8'd0, 8'd0);
    tbl[6]  = mk("raw_x5_2",     0, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_HOLD, 6'h00, 3'd2, 8'd1, 8'd0);
    tbl[7]  = mk("raw_x5_3",     0, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_HOLD, 6'h00, 3'd2, 8'd2, 8'd0);
    tbl[8]  = mk("raw_x5_go",    0, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_RUN,  6'h00, 3'd2, 8'd3, 8'd0);
    tbl[9]  = mk("wr_x7",        0, 5'd5, 1, 5'd0, 0, 5'd7, 1, 0, 6'h00, 0, P_RUN,  6'h00, 3'd1, 8'd3, 8'd0);
    tbl[10] = mk("raw_x7",       0, 5'd0, 0, 5'd7, 1, 5'd0, 0, 0, 6'h00, 0, P_HOLD, 6'h00, 3'd1, 8'd3, 8'd0);
    tbl[11] = mk("br_in_stall",  0, 5'd0, 0, 5'd7, 1, 5'd0, 0, 1, 6'h2A, 0, P_BR,   6'h2A, 3'd2, 8'd4, 8'd0);
    tbl[12] = mk("flush_no_br",  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 6'h11, 0, P_RUN,  6'h00, 3'd3, 8'd4, 8'd1);
    tbl[13] = mk("br_over_halt", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 6'h15, 1, P_BR,   6'h15, 3'd1, 8'd4, 8'd1);
    tbl[14] = mk("halt_flush",   0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 1, P_HOLD, 6'h00, 3'd3, 8'd4, 8'd2);
    tbl[15] = mk("drain_no_br",  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 6'h3F, 1, P_HOLD, 6'h00, 3'd4, 8'd4, 8'd2);
    tbl[16] = mk("halted",       0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 6'h3F, 0, P_HLT,  6'h00, 3'd5, 8'd4, 8'd2);
    tbl[17] = mk("halted_hold",  0, 5'd3, 1, 5'd0, 0, 5'd3, 1, 0, 6'h00, 0, P_HLT,  6'h00, 3'd5, 8'd4, 8'd2);

    resetIn = 1'b1; decRead1 = 5'd0; decRead2 = 5'd0; decUse1 = 1'b0; decUse2 = 1'b0;
    decWrite = 5'd0; decWriteEnable = 1'b0; branchTaken = 1'b0; branchTarget = 6'd0;
    haltReq = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i]);
    end

    // Halt with three valid scoreboard entries; the halting instruction's write is dropped.
    step(mk("a_rst",    1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_HOLD, 6'h00, 3'd5, 8'd4, 8'd2));
    step(mk("a_idle",   0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_HOLD, 6'h00, 3'd0, 8'd0, 8'd0));
    step(mk("a_wr1",    0, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 6'h00, 0, P_RUN,  6'h00, 3'd1, 8'd0, 8'd0));
    step(mk("a_wr2",    0, 5'd0, 0, 5'd0, 0, 5'd2, 1, 0, 6'h00, 0, P_RUN,  6'h00, 3'd1, 8'd0, 8'd0));
    step(mk("a_wr3",    0, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 6'h00, 0, P_RUN,  6'h00, 3'd1, 8'd0, 8'd0));
    step(mk("a_halt",   0, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 6'h00, 1, P_HOLD, 6'h00, 3'd1, 8'd0, 8'd0));
    step(mk("a_drain1", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 1, P_HOLD, 6'h00, 3'd4, 8'd0, 8'd0));
    step(mk("a_drain2", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 1, P_HOLD, 6'h00, 3'd4, 8'd0, 8'd0));
    step(mk("a_drain3", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_HOLD, 6'h00, 3'd4, 8'd0, 8'd0));
    step(mk("a_halted1",0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_HLT,  6'h00, 3'd5, 8'd0, 8'd0));
    step(mk("a_halted2",0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_HLT,  6'h00, 3'd5, 8'd0, 8'd0));

    // Halt deferred by hazards, then reset while draining.
    step(mk("b_rst",      1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_HOLD, 6'h00, 3'd5, 8'd0, 8'd0));
    step(mk("b_idle",     0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_HOLD, 6'h00, 3'd0, 8'd0, 8'd0));
    step(mk("b_wr4",      0, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 6'h00, 0, P_RUN,  6'h00, 3'd1, 8'd0, 8'd0));
    step(mk("b_haz1",     0, 5'd4, 1, 5'd0, 0, 5'd0, 0, 0, 6'h00, 1, P_HOLD, 6'h00, 3'd1, 8'd0, 8'd0));
    step(mk("b_haz2",     0, 5'd4, 1, 5'd0, 0, 5'd0, 0, 0, 6'h00, 1, P_HOLD, 6'h00, 3'd2, 8'd1, 8'd0));
    step(mk("b_haz3",     0, 5'd4, 1, 5'd0, 0, 5'd0, 0, 0, 6'h00, 1, P_HOLD, 6'h00, 3'd2, 8'd2, 8'd0));
    step(mk("b_halt_go",  0, 5'd4, 1, 5'd0, 0, 5'd0, 0, 0, 6'h00, 1, P_HOLD, 6'h00, 3'd2, 8'd3, 8'd0));
    step(mk("b_rst_drain",1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 1, P_HOLD, 6'h00, 3'd4, 8'd3, 8'd0));
    step(mk("b_post_rst", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_HOLD, 6'h00, 3'd0, 8'd0, 8'd0));
    step(mk("b_run",      0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_RUN,  6'h00, 3'd1, 8'd0, 8'd0));

    // Saturation: an instruction that reads and writes x9 repeats, giving
    // three stall cycles then one issue cycle; 400 cycles yield 300 stalls.
    step(mk("c_rst",  1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_HOLD, 6'h00, 3'd1, 8'd0, 8'd0));
    step(mk("c_idle", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_HOLD, 6'h00, 3'd0, 8'd0, 8'd0));
    haz = 0;
    for (int k = 0; k < 400; k++) begin
      v = mk($sformatf("sat_%0d", k), 0, 5'd9, 1, 5'd0, 0, 5'd9, 1, 0, 6'h00, 0,
             P_RUN, 6'h00, 3'd1, 8'd0, 8'd0);
      if ((k % 4) == 0) begin
        v.e_ctrl  = P_RUN;
        v.e_state = (k == 0) ? 3'd1 : 3'd2;
      end else begin
        v.e_ctrl  = P_HOLD;
        v.e_state = ((k % 4) == 1) ? 3'd1 : 3'd2;
      end
      v.e_stall = (haz > 255) ? 8'd255 : 8'(haz);
      step(v);
      if ((k % 4) != 0) begin
        haz++;
      end
    end
    step(mk("c_final1", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_RUN, 6'h00, 3'd2, 8'd255, 8'd0));
    step(mk("c_final2", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 6'h00, 0, P_RUN, 6'h00, 3'd1, 8'd255, 8'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
